idu_pipe: RTL and testbench

IDU_PIPE -- requirements
Module: idu_pipe

---
 rtl/idu_pipe.sv | 217 +++++++++++++++++++++
 tb/tb_idu_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_pipe.sv
// -----------------------------------------------------------------------------
// idu_pipe : single-stage RISC-V instruction decode pipeline register.
//
// Decodes an incoming 32-bit instruction combinationally and captures the
// decode result, together with the raw instruction and its PC, on every input
// transfer (in_valid && in_ready). The output stage uses a valid/ready
// handshake and holds its data stable under backpressure. A 32-bit counter
// counts completed output transfers.
//
// Parameters
//   XLEN      datapath width, 32 or 64
//   RV64_OPS  1 with XLEN=64 makes OP-32 / OP-IMM-32 legal
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   flush                    drop held output and block input this cycle
//   in_valid / in_ready      upstream handshake
//   in_inst, in_pc           instruction word and its PC
//   out_valid / out_ready    downstream handshake
//   out_pc, out_inst         registered copies of the input
//   out_rs1/out_rs2/out_rd   register specifiers
//   out_imm                  sign-extended immediate (0 for R and N formats)
//   out_type                 format R=0 I=1 S=2 B=3 U=4 J=5 N=6
//   out_rd_wen               destination register is written
//   out_illegal              opcode not recognised
//   out_count                output transfer counter, wraps at 2^32
// -----------------------------------------------------------------------------
module idu_pipe #(
    parameter int XLEN     = 32,
    parameter bit RV64_OPS = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_rd_wen,
    output logic            out_illegal,
    output logic [31:0]     out_count
);

    localparam logic [2:0] TYPE_R = 3'd0;
    localparam logic [2:0] TYPE_I = 3'd1;
    localparam logic [2:0] TYPE_S = 3'd2;
    localparam logic [2:0] TYPE_B = 3'd3;
    localparam logic [2:0] TYPE_U = 3'd4;
    localparam logic [2:0] TYPE_J = 3'd5;
    localparam logic [2:0] TYPE_N = 3'd6;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP_32    = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;

    // The 32-bit-word opcodes only exist on a 64-bit datapath.
    localparam bit RV64_EN = (RV64_OPS == 1'b1) && (XLEN == 32'sd64);

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [2:0]      type_s;
    logic [31:0]     imm32_s;
    logic [XLEN-1:0] imm_s;
    logic            wen_s;
    logic            in_fire_s;
    logic            out_fire_s;

    logic            valid_r;
    logic [XLEN-1:0] pc_r;
    logic [31:0]     inst_r;
    logic [XLEN-1:0] imm_r;
    logic [2:0]      type_r;
    logic            wen_r;
    logic [31:0]     count_r;

    // Opcode to instruction format; anything unrecognised is format N.
    always_comb begin
        opcode_s = in_inst[6:0];
        funct3_s = in_inst[14:12];
        type_s   = TYPE_N;
        if (in_inst[1:0] != 2'b11) begin
            type_s = TYPE_N;
        end else begin
            case (opcode_s)
                OPC_OP:       type_s = TYPE_R;
                OPC_OP_IMM,
                OPC_LOAD,
                OPC_JALR,
                OPC_SYSTEM,
                OPC_FENCE:    type_s = TYPE_I;
                OPC_STORE:    type_s = TYPE_S;
                OPC_BRANCH:   type_s = TYPE_B;
                OPC_LUI,
                OPC_AUIPC:    type_s = TYPE_U;
                OPC_JAL:      type_s = TYPE_J;
                OPC_OP_32: begin
                    if (RV64_EN) type_s = TYPE_R;
                    else         type_s = TYPE_N;
                end
                OPC_OP_IMM32: begin
                    if (RV64_EN) type_s = TYPE_I;
                    else         type_s = TYPE_N;
                end
                default:      type_s = TYPE_N;
            endcase
        end
    end

    // Immediate assembly: built as a sign-extended 32-bit value, then
    // sign-extended again to the datapath width.
    always_comb begin
        imm32_s = 32'h0000_0000;
        case (type_s)
            TYPE_I:  imm32_s = {{20{in_inst[31]}}, in_inst[31:20]};
            TYPE_S:  imm32_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            TYPE_B:  imm32_s = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                in_inst[30:25], in_inst[11:8], 1'b0};
            TYPE_U:  imm32_s = {in_inst[31:12], 12'h000};
            TYPE_J:  imm32_s = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                in_inst[20], in_inst[30:21], 1'b0};
            default: imm32_s = 32'h0000_0000;
        endcase
        imm_s = XLEN'(signed'(imm32_s));
    end

    // Register write enable: FENCE and ECALL/EBREAK (SYSTEM funct3=0) are
    // I-format but never write rd.
    always_comb begin
        wen_s = 1'b0;
        if (((type_s == TYPE_R) || (type_s == TYPE_I) ||
             (type_s == TYPE_U) || (type_s == TYPE_J)) &&
            (in_inst[11:7] != 5'd0) &&
            (opcode_s != OPC_FENCE) &&
            !((opcode_s == OPC_SYSTEM) && (funct3_s == 3'b000))) begin
            wen_s = 1'b1;
        end else begin
            wen_s = 1'b0;
        end
    end

    assign in_ready   = (!valid_r || out_ready) && !flush;
    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = valid_r && out_ready;

    // Output valid flag: flush wins over a load; a drain without refill
    // empties the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (in_fire_s) begin
            valid_r <= 1'b1;
        end else if (out_fire_s) begin
            valid_r <= 1'b0;
        end
    end

    // Decoded data registers: only written on an input transfer, so they hold
    // under backpressure and across a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r   <= '0;
            inst_r <= 32'h0000_0000;
            imm_r  <= '0;
            type_r <= TYPE_N;
            wen_r  <= 1'b0;
        end else if (in_fire_s) begin
            pc_r   <= in_pc;
            inst_r <= in_inst;
            imm_r  <= imm_s;
            type_r <= type_s;
            wen_r  <= wen_s;
        end
    end

    // Transfer counter: an output transfer in a flush cycle still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 32'h0000_0000;
        end else if (out_fire_s) begin
            count_r <= count_r + 32'd1;
        end
    end

    assign out_valid   = valid_r;
    assign out_pc      = pc_r;
    assign out_inst    = inst_r;
    assign out_rs1     = inst_r[19:15];
    assign out_rs2     = inst_r[24:20];
    assign out_rd      = inst_r[11:7];
    assign out_imm     = imm_r;
    assign out_type    = type_r;
    assign out_rd_wen  = wen_r;
    assign out_illegal = (type_r == TYPE_N);
    assign out_count   = count_r;

endmodule

// File: tb/tb_idu_pipe.sv
module tb_idu_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    logic        r32_ready, r32_valid, r32_wen, r32_ill;
    logic [31:0] r32_pc, r32_inst, r32_imm, r32_count;
    logic [4:0]  r32_rs1, r32_rs2, r32_rd;
    logic [2:0]  r32_type;

    logic        r64_ready, r64_valid, r64_wen, r64_ill;
    logic [63:0] r64_pc, r64_imm;
    logic [31:0] r64_inst, r64_count;
    logic [4:0]  r64_rs1, r64_rs2, r64_rd;
    logic [2:0]  r64_type;

    idu_pipe #(.XLEN(32), .RV64_OPS(1'b0)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(r32_ready),
        .in_inst(in_inst), .in_pc(in_pc[31:0]),
        .out_valid(r32_valid), .out_ready(out_ready),
        .out_pc(r32_pc), .out_inst(r32_inst),
        .out_rs1(r32_rs1), .out_rs2(r32_rs2), .out_rd(r32_rd),
        .out_imm(r32_imm), .out_type(r32_type),
        .out_rd_wen(r32_wen), .out_illegal(r32_ill), .out_count(r32_count)
    );

    idu_pipe #(.XLEN(64), .RV64_OPS(1'b1)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(r64_ready),
        .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(r64_valid), .out_ready(out_ready),
        .out_pc(r64_pc), .out_inst(r64_inst),
        .out_rs1(r64_rs1), .out_rs2(r64_rs2), .out_rd(r64_rd),
        .out_imm(r64_imm), .out_type(r64_type),
        .out_rd_wen(r64_wen), .out_illegal(r64_ill), .out_count(r64_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        wen;
        logic        ill;
    } exp_t;

    exp_t        q32[$];
    exp_t        q64[$];
    int          n_vec;
    int          n_bad;
    logic [31:0] exp_cnt;

    localparam int NTBL = 15;
    localparam logic [31:0] TBL [NTBL] = '{
        32'h00500093, 32'hFE20AE23, 32'h123452B7, 32'hFF9FF06F, 32'h0000000F,
        32'h00000073, 32'h34202573, 32'h00B50533, 32'h00B5053B, 32'h0015051B,
        32'hFE000EE3, 32'h00001517, 32'h0040A103, 32'h000080E7, 32'hFFFFFFFF
    };

    // Reference decoder for one instruction.
    function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc, input bit rv64);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] t;
        op = i[6:0];
        t  = 3'd6;
        if (i[1:0] == 2'b11) begin
            if (op == 7'b0110011) t = 3'd0;
            else if (op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111}) t = 3'd1;
            else if (op == 7'b0100011) t = 3'd2;
            else if (op == 7'b1100011) t = 3'd3;
            else if (op inside {7'b0110111, 7'b0010111}) t = 3'd4;
            else if (op == 7'b1101111) t = 3'd5;
            else if (rv64 && op == 7'b0111011) t = 3'd0;
            else if (rv64 && op == 7'b0011011) t = 3'd1;
        end
        e.inst = i;
        e.pc   = pc;
        e.rs1  = i[19:15];
        e.rs2  = i[24:20];
        e.rd   = i[11:7];
        e.typ  = t;
        case (t)
            3'd1:    e.imm = {{52{i[31]}}, i[31:20]};
            3'd2:    e.imm = {{52{i[31]}}, i[31:25], i[11:7]};
            3'd3:    e.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4:    e.imm = {{32{i[31]}}, i[31:12], 12'h000};
            3'd5:    e.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: e.imm = 64'h0;
        endcase
        e.wen = (t inside {3'd0, 3'd1, 3'd4, 3'd5}) && (i[11:7] != 5'd0) &&
                (op != 7'b0001111) && !(op == 7'b1110011 && i[14:12] == 3'b000);
        e.ill = (t == 3'd6);
        return e;
    endfunction

    // Scoreboard: pushes on input transfers, pops and compares on output transfers.
    task automatic mon();
        exp_t         e;
        logic [115:0] a32, w32;
        logic [179:0] a64, w64;
        if (rst) begin
            q32.delete();
            q64.delete();
            exp_cnt = 32'd0;
            return;
        end
        n_vec++;
        if (r32_count !== exp_cnt) begin n_bad++; $display("FAIL count32 got %h want %h", r32_count, exp_cnt); end
        n_vec++;
        if (r64_count !== exp_cnt) begin n_bad++; $display("FAIL count64 got %h want %h", r64_count, exp_cnt); end
        if (r32_valid && out_ready) begin
            n_vec++;
            if (q32.size() == 0) begin
                n_bad++; $display("FAIL out32 unexpected output got inst %h want none", r32_inst);
            end else begin
                e   = q32.pop_front();
                a32 = {r32_inst, r32_pc, r32_rs1, r32_rs2, r32_rd, r32_imm, r32_type, r32_wen, r32_ill};
                w32 = {e.inst, e.pc[31:0], e.rs1, e.rs2, e.rd, e.imm[31:0], e.typ, e.wen, e.ill};
                if (a32 !== w32) begin n_bad++; $display("FAIL out32 got %h want %h", a32, w32); end
            end
            exp_cnt = exp_cnt + 32'd1;
        end else if (r32_valid && flush && q32.size() > 0) begin
            void'(q32.pop_front());
        end
        if (r64_valid && out_ready) begin
            n_vec++;
            if (q64.size() == 0) begin
                n_bad++; $display("FAIL out64 unexpected output got inst %h want none", r64_inst);
            end else begin
                e   = q64.pop_front();
                a64 = {r64_inst, r64_pc, r64_rs1, r64_rs2, r64_rd, r64_imm, r64_type, r64_wen, r64_ill};
                w64 = {e.inst, e.pc, e.rs1, e.rs2, e.rd, e.imm, e.typ, e.wen, e.ill};
                if (a64 !== w64) begin n_bad++; $display("FAIL out64 got %h want %h", a64, w64); end
            end
        end else if (r64_valid && flush && q64.size() > 0) begin
            void'(q64.pop_front());
        end
        if (in_valid && r32_ready) q32.push_back(model(in_inst, in_pc, 1'b0));
        if (in_valid && r64_ready) q64.push_back(model(in_inst, in_pc, 1'b1));
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        do_reset();
        n_vec += 9;
        if (r32_valid !== 1'b0)   begin n_bad++; $display("FAIL rst_valid got %b want 0", r32_valid); end
        if (r32_count !== 32'd0)  begin n_bad++; $display("FAIL rst_count got %h want 0", r32_count); end
        if (r32_type !== 3'd6)    begin n_bad++; $display("FAIL rst_type got %0d want 6", r32_type); end
        if (r32_imm !== 32'd0)    begin n_bad++; $display("FAIL rst_imm got %h want 0", r32_imm); end
        if (r32_inst !== 32'd0)   begin n_bad++; $display("FAIL rst_inst got %h want 0", r32_inst); end
        if (r32_pc !== 32'd0)     begin n_bad++; $display("FAIL rst_pc got %h want 0", r32_pc); end
        if (r32_wen !== 1'b0)     begin n_bad++; $display("FAIL rst_wen got %b want 0", r32_wen); end
        if (r64_type !== 3'd6)    begin n_bad++; $display("FAIL rst_type64 got %0d want 6", r64_type); end
        if (r32_ready !== 1'b1)   begin n_bad++; $display("FAIL rst_in_ready got %b want 1", r32_ready); end
    endtask

    task automatic test_spec_vectors();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 64'h1000; cyc(); in_valid = 1'b0;
        n_vec += 6;
        if (r32_valid !== 1'b1)        begin n_bad++; $display("FAIL addi_valid got %b want 1", r32_valid); end
        if (r32_rs1 !== 5'd0)          begin n_bad++; $display("FAIL addi_rs1 got %0d want 0", r32_rs1); end
        if (r32_rd !== 5'd1)           begin n_bad++; $display("FAIL addi_rd got %0d want 1", r32_rd); end
        if (r32_imm !== 32'd5)         begin n_bad++; $display("FAIL addi_imm got %h want 5", r32_imm); end
        if (r32_type !== 3'd1)         begin n_bad++; $display("FAIL addi_type got %0d want 1", r32_type); end
        if (r32_wen !== 1'b1)          begin n_bad++; $display("FAIL addi_wen got %b want 1", r32_wen); end
        cyc();
        in_valid = 1'b1; in_inst = 32'hFE20AE23; in_pc = 64'h1004; cyc(); in_valid = 1'b0;
        n_vec += 5;
        if (r32_imm !== 32'hFFFFFFFC)  begin n_bad++; $display("FAIL sw_imm got %h want fffffffc", r32_imm); end
        if (r32_rs1 !== 5'd1)          begin n_bad++; $display("FAIL sw_rs1 got %0d want 1", r32_rs1); end
        if (r32_rs2 !== 5'd2)          begin n_bad++; $display("FAIL sw_rs2 got %0d want 2", r32_rs2); end
        if (r32_type !== 3'd2)         begin n_bad++; $display("FAIL sw_type got %0d want 2", r32_type); end
        if (r32_wen !== 1'b0)          begin n_bad++; $display("FAIL sw_wen got %b want 0", r32_wen); end
        cyc();
        in_valid = 1'b1; in_inst = 32'h123452B7; in_pc = 64'h1008; cyc(); in_valid = 1'b0;
        n_vec += 2;
        if (r32_imm !== 32'h12345000)  begin n_bad++; $display("FAIL lui_imm got %h want 12345000", r32_imm); end
        if (r32_wen !== 1'b1)          begin n_bad++; $display("FAIL lui_wen got %b want 1", r32_wen); end
        cyc();
        in_valid = 1'b1; in_inst = 32'hFF9FF06F; in_pc = 64'h100C; cyc(); in_valid = 1'b0;
        n_vec += 3;
        if (r64_imm !== 64'hFFFFFFFFFFFFFFF8) begin n_bad++; $display("FAIL jal_imm got %h want fffffffffffffff8", r64_imm); end
        if (r64_type !== 3'd5)         begin n_bad++; $display("FAIL jal_type got %0d want 5", r64_type); end
        if (r64_wen !== 1'b0)          begin n_bad++; $display("FAIL jal_wen got %b want 0", r64_wen); end
        cyc();
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < NTBL; i++) begin
            in_valid = 1'b1; in_inst = TBL[i]; in_pc = 64'hFFFF_0000_8000_0000 + 64'(i * 4);
            cyc();
            n_vec++;
            if (r32_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid got %b want 1", r32_valid); end
        end
        in_valid = 1'b0;
        cyc();
        n_vec += 2;
        if (r32_count !== 32'd15) begin n_bad++; $display("FAIL b2b_count got %0d want 15", r32_count); end
        if (r32_valid !== 1'b0)   begin n_bad++; $display("FAIL b2b_drain got %b want 0", r32_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 64'h2000; cyc();
        in_inst = 32'h123452B7; in_pc = 64'h2004;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_vec += 3;
            if (r32_ready !== 1'b0)        begin n_bad++; $display("FAIL bp_in_ready got %b want 0", r32_ready); end
            if (r32_valid !== 1'b1)        begin n_bad++; $display("FAIL bp_valid got %b want 1", r32_valid); end
            if (r32_inst !== 32'h00500093) begin n_bad++; $display("FAIL bp_hold got %h want 00500093", r32_inst); end
        end
        out_ready = 1'b1;
        cyc();
        n_vec++;
        if (r32_inst !== 32'h123452B7) begin n_bad++; $display("FAIL bp_second got %h want 123452b7", r32_inst); end
        in_valid = 1'b0;
        cyc();
        n_vec += 2;
        if (r32_count !== 32'd2)  begin n_bad++; $display("FAIL bp_count got %0d want 2", r32_count); end
        if (r32_valid !== 1'b0)   begin n_bad++; $display("FAIL bp_drain got %b want 0", r32_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00000000; in_pc = 64'h3000; cyc(); in_valid = 1'b0;
        n_vec += 2;
        if (r32_type !== 3'd6) begin n_bad++; $display("FAIL ill_type got %0d want 6", r32_type); end
        if (r32_ill !== 1'b1)  begin n_bad++; $display("FAIL ill_flag got %b want 1", r32_ill); end
        out_ready = 1'b1; cyc();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 64'h3004; cyc();
        flush = 1'b1; in_inst = 32'h123452B7; #1;
        n_vec++;
        if (r32_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready got %b want 0", r32_ready); end
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        n_vec += 3;
        if (r32_valid !== 1'b0)        begin n_bad++; $display("FAIL flush_valid got %b want 0", r32_valid); end
        if (r32_count !== 32'd1)       begin n_bad++; $display("FAIL flush_count got %0d want 1", r32_count); end
        if (r32_inst !== 32'h00500093) begin n_bad++; $display("FAIL flush_data got %h want 00500093", r32_inst); end
        in_valid = 1'b1; in_inst = 32'h0015051B; in_pc = 64'h3008; cyc(); in_valid = 1'b0;
        flush = 1'b1; out_ready = 1'b1; cyc(); flush = 1'b0;
        n_vec += 2;
        if (r32_count !== 32'd2) begin n_bad++; $display("FAIL flush_xfer_count got %0d want 2", r32_count); end
        if (r32_valid !== 1'b0)  begin n_bad++; $display("FAIL flush_xfer_valid got %b want 0", r32_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        force dut32.count_r = 32'hFFFFFFFF;
        force dut64.count_r = 32'hFFFFFFFF;
        #1;
        release dut32.count_r;
        release dut64.count_r;
        exp_cnt = 32'hFFFFFFFF;
        in_valid = 1'b1; in_inst = 32'h00B50533; in_pc = 64'h4000; cyc(); in_valid = 1'b0;
        cyc();
        n_vec += 2;
        if (r32_count !== 32'd0) begin n_bad++; $display("FAIL wrap32 got %h want 0", r32_count); end
        if (r64_count !== 32'd0) begin n_bad++; $display("FAIL wrap64 got %h want 0", r64_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'hFE000EE3; in_pc = 64'h5000; cyc();
        out_ready = 1'b0; in_inst = 32'h123452B7; in_pc = 64'h5004; cyc();
        in_inst = 32'hFF9FF06F; rst = 1'b1; cyc();
        in_valid = 1'b0;
        n_vec += 8;
        if (r32_valid !== 1'b0)  begin n_bad++; $display("FAIL mid_valid got %b want 0", r32_valid); end
        if (r32_count !== 32'd0) begin n_bad++; $display("FAIL mid_count got %h want 0", r32_count); end
        if (r32_type !== 3'd6)   begin n_bad++; $display("FAIL mid_type got %0d want 6", r32_type); end
        if (r32_imm !== 32'd0)   begin n_bad++; $display("FAIL mid_imm got %h want 0", r32_imm); end
        if (r32_inst !== 32'd0)  begin n_bad++; $display("FAIL mid_inst got %h want 0", r32_inst); end
        if (r32_rd !== 5'd0)     begin n_bad++; $display("FAIL mid_rd got %0d want 0", r32_rd); end
        if (r64_pc !== 64'd0)    begin n_bad++; $display("FAIL mid_pc64 got %h want 0", r64_pc); end
        if (r64_imm !== 64'd0)   begin n_bad++; $display("FAIL mid_imm64 got %h want 0", r64_imm); end
        rst = 1'b0; #1;
        n_vec++;
        if (r32_ready !== 1'b1)  begin n_bad++; $display("FAIL mid_in_ready got %b want 1", r32_ready); end
        cyc();
        n_vec++;
        if (r32_valid !== 1'b0)  begin n_bad++; $display("FAIL mid_dropped got %b want 0", r32_valid); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'd0; in_pc = 64'd0;
        n_vec = 0; n_bad = 0; exp_cnt = 32'd0;
        @(posedge clk); #1;
        test_reset();
        test_spec_vectors();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
